// File: rtl/ws2812_rx.sv
// WS2812 single-wire RZ receiver: decodes GRB pixels, flags frame gaps and errors, forwards the cascade.
// Events register 3 cycles after rz_in is first sampled low; no backpressure, outputs are one-cycle pulses.
module ws2812_rx #(
    parameter int T_MIN    = 8,
    parameter int T_THRESH = 30,
    parameter int T_MAXH   = 55,
    parameter int T_RESET  = 2500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rz_in,
    output logic [23:0] rgb_data,
    output logic        rgb_valid,
    output logic [15:0] pix_cnt,
    output logic        frame_end,
    output logic        err,
    output logic        rz_out
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW, ERR} state_t;

    state_t      state;
    logic        rz_m;
    logic        rz_s;
    logic        rz_d;
    logic [15:0] wcnt;
    logic [15:0] lcnt;
    logic [22:0] shift;
    logic [4:0]  bit_cnt;
    logic        fwd;
    logic        rise;
    logic        fall;
    logic        bit_val;
    logic        width_bad;
    logic        gap_done;

    assign rise      = rz_s & ~rz_d;
    assign fall      = ~rz_s & rz_d;
    assign bit_val   = (wcnt >= 16'(T_THRESH));
    assign width_bad = (wcnt < 16'(T_MIN)) || (wcnt > 16'(T_MAXH));
    assign gap_done  = (lcnt >= 16'(T_RESET - 1));
    assign rz_out    = fwd & rz_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rz_m      <= 1'b0;
            rz_s      <= 1'b0;
            rz_d      <= 1'b0;
            state     <= IDLE;
            wcnt      <= '0;
            lcnt      <= '0;
            shift     <= '0;
            bit_cnt   <= '0;
            fwd       <= 1'b0;
            rgb_data  <= '0;
            rgb_valid <= 1'b0;
            pix_cnt   <= '0;
            frame_end <= 1'b0;
            err       <= 1'b0;
        end else begin
            rz_m      <= rz_in;
            rz_s      <= rz_m;
            rz_d      <= rz_s;
            rgb_valid <= 1'b0;
            frame_end <= 1'b0;
            err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= HIGH;
                        wcnt  <= 16'd1;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        lcnt <= 16'd1;
                        if (width_bad) begin
                            err     <= 1'b1;
                            fwd     <= 1'b0;
                            bit_cnt <= '0;
                            state   <= ERR;
                        end else begin
                            state <= LOW;
                            if (bit_cnt == 5'd23) begin
                                rgb_data  <= {shift, bit_val};
                                rgb_valid <= 1'b1;
                                bit_cnt   <= '0;
                                if (pix_cnt != 16'hFFFF)
                                    pix_cnt <= pix_cnt + 16'd1;
                                if (pix_cnt == 16'd0)
                                    fwd <= 1'b1;
                            end else begin
                                shift   <= {shift[21:0], bit_val};
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end else if (wcnt != 16'hFFFF) begin
                        wcnt <= wcnt + 16'd1;
                    end
                end
                LOW: begin
                    if (rise) begin
                        state <= HIGH;
                        wcnt  <= 16'd1;
                    end else if (gap_done) begin
                        // A gap mid-pixel is a truncated pixel, not a frame boundary.
                        if (bit_cnt == 5'd0)
                            frame_end <= 1'b1;
                        else
                            err <= 1'b1;
                        state   <= IDLE;
                        pix_cnt <= '0;
                        bit_cnt <= '0;
                        fwd     <= 1'b0;
                    end else begin
                        lcnt <= lcnt + 16'd1;
                    end
                end
                ERR: begin
                    if (rz_s) begin
                        lcnt <= '0;
                    end else if (gap_done) begin
                        state   <= IDLE;
                        pix_cnt <= '0;
                        bit_cnt <= '0;
                        fwd     <= 1'b0;
                    end else begin
                        lcnt <= lcnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
